// File: rtl/mul_nw_iter.sv
// mul_nw_iter: iterative unsigned DW x DW -> 2*DW multiplier.
// Operand A is consumed one TW-bit limb per cycle. Each limb is multiplied
// against all of B through L tile multipliers. The shifted partial product
// is added into a 2*DW accumulator. Handshake: valid/ready in,
// one-cycle fin pulse out, plus a synchronous flush.

// One TW x TW tile of the partial product.
module mul_nw_tile #(
    parameter int TW = 32
) (
    input  logic [TW-1:0]   x,
    input  logic [TW-1:0]   y,
    output logic [2*TW-1:0] p
);
    assign p = (2*TW)'(x) * (2*TW)'(y);
endmodule

module mul_nw_iter #(
    parameter int DW = 64,
    parameter int TW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_vld_i,
    input  logic [DW-1:0]   mul_a_i,
    input  logic [DW-1:0]   mul_b_i,
    input  logic            mul_clr_i,
    output logic            mul_rdy_o,
    output logic            mul_fin_o,
    output logic [2*DW-1:0] mul_r_o
);
    localparam int L  = DW / TW;
    localparam int RW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t                  state, state_nxt;
    logic [DW-1:0]           a_q, b_q;
    logic [2*DW-1:0]         acc, acc_nxt, r_q;
    logic [RW-1:0]           row;
    logic                    fin_q;
    logic                    last_row;
    logic [TW-1:0]           limb;
    logic [L-1:0][2*TW-1:0]  tile;
    logic [TW+DW-1:0]        pp;

    // The limb of A that this cycle's row works on.
    assign limb     = a_q[int'(row) * TW +: TW];
    assign last_row = (row == RW'(L - 1));

    // One tile multiplier per B-limb, all fed the same A-limb.
    for (genvar j = 0; j < L; j++) begin : g_tile
        mul_nw_tile #(.TW(TW)) u_tile (
            .x (limb),
            .y (b_q[j*TW +: TW]),
            .p (tile[j])
        );
    end

    // Combine the tiles into limb*B, then place it at the row's weight.
    always_comb begin
        pp = '0;
        for (int j = 0; j < L; j++) begin
            pp = pp + ((TW+DW)'(tile[j]) << (j * TW));
        end
        acc_nxt = acc + ((2*DW)'(pp) << (int'(row) * TW));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; flush overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_vld_i) state_nxt = CALC;
            CALC:    if (last_row)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (mul_clr_i) state_nxt = IDLE;
    end

    // Operand capture, row accumulation and result/fin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            row   <= '0;
            r_q   <= '0;
            fin_q <= 1'b0;
        end else if (mul_clr_i) begin
            // The result register keeps the last completed product.
            row   <= '0;
            fin_q <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_vld_i) begin
                        a_q <= mul_a_i;
                        b_q <= mul_b_i;
                        acc <= '0;
                        row <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (last_row) begin
                        r_q   <= acc_nxt;
                        fin_q <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_rdy_o = (state == IDLE);
    assign mul_fin_o = fin_q;
    assign mul_r_o   = r_q;
endmodule

// File: tb/tb_mul_nw_iter.sv
// Bench for mul_nw_iter: two instances (64/32 and 256/64). A negedge
// scoreboard tracks each instance from the handshake rules. The stimulus
// is a vector table, hand-written flush and reset sequences, and a
// randomized back-to-back run.
module tb_mul_nw_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]        vld, clr, rdy, fin;
    logic [1:0][255:0] a, b;
    logic [127:0]      r0;
    logic [511:0]      r1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    mul_nw_iter #(.DW(64), .TW(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mul_vld_i(vld[0]), .mul_a_i(a[0][63:0]),
        .mul_b_i(b[0][63:0]), .mul_clr_i(clr[0]), .mul_rdy_o(rdy[0]),
        .mul_fin_o(fin[0]), .mul_r_o(r0)
    );

    mul_nw_iter #(.DW(256), .TW(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mul_vld_i(vld[1]), .mul_a_i(a[1]),
        .mul_b_i(b[1]), .mul_clr_i(clr[1]), .mul_rdy_o(rdy[1]),
        .mul_fin_o(fin[1]), .mul_r_o(r1)
    );

    function automatic int lsel(input int sel);
        return (sel != 0) ? 4 : 2;
    endfunction

    function automatic logic [511:0] rsel(input int sel);
        return (sel != 0) ? r1 : {384'b0, r0};
    endfunction

    // Reference product: plain wide multiply of the operands as seen by the instance.
    function automatic logic [511:0] ref_mul(input int sel, input logic [255:0] x, input logic [255:0] y);
        logic [511:0] xm, ym;
        xm = (sel != 0) ? {256'b0, x} : {448'b0, x[63:0]};
        ym = (sel != 0) ? {256'b0, y} : {448'b0, y[63:0]};
        return xm * ym;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        int mode;
        mode = int'($urandom_range(0, 9));
        if (mode == 0)      v = '1;
        else if (mode == 1) v = '0;
        else for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: at most one operation in flight per instance.
    bit           pend  [2] = '{default: 1'b0};
    logic [511:0] pprod [2];
    logic [511:0] last_r[2] = '{default: '0};
    int           due   [2] = '{default: 0};
    int           n_acc [2] = '{default: 0};
    int           ncyc = 0;

    always @(negedge clk) begin
        logic [511:0] rr;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                rr = rsel(i);
                if (!rst_n) begin
                    pend[i]   = 1'b0;
                    last_r[i] = '0;
                    chk("rst_fin", 512'(fin[i]), 512'd0);
                    chk("rst_rdy", 512'(rdy[i]), 512'd1);
                    chk("rst_r", rr, 512'd0);
                end else begin
                    if (fin[i]) begin
                        chk("fin_timing", 512'(pend[i] && due[i] == ncyc), 512'd1);
                        chk("fin_result", rr, pprod[i]);
                        pend[i]   = 1'b0;
                        last_r[i] = pprod[i];
                    end else begin
                        chk("fin_missing", 512'(pend[i] && due[i] <= ncyc), 512'd0);
                        chk("r_hold", rr, last_r[i]);
                    end
                    chk("rdy", 512'(rdy[i]), 512'(!pend[i]));
                    // Inputs seen now are what the next rising edge samples.
                    if (clr[i]) begin
                        pend[i] = 1'b0;
                    end else if (vld[i] && !pend[i]) begin
                        pend[i]  = 1'b1;
                        pprod[i] = ref_mul(i, a[i], b[i]);
                        due[i]   = ncyc + lsel(i) + 1;
                        n_acc[i]++;
                    end
                end
            end
        end
        ncyc++;
    end

    // Single operation with latency and ready-low checks.
    task automatic do_op(input int sel, input logic [255:0] av, input logic [255:0] bv,
                         input logic [511:0] exp, input string nm);
        int lat, low;
        bit got;
        @(posedge clk); #1;
        a[sel] = av; b[sel] = bv; vld[sel] = 1'b1;
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        got = 1'b0; lat = 0; low = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (!rdy[sel]) low++;
            if (fin[sel]) begin
                got = 1'b1;
                lat = c - 1;
            end
        end
        chk({nm, "_fin_seen"}, 512'(got), 512'd1);
        chk({nm, "_latency"}, 512'(lat), 512'(lsel(sel)));
        chk({nm, "_rdy_low"}, 512'(low), 512'(lsel(sel)));
        chk(nm, rsel(sel), exp);
    endtask

    task automatic no_fin(input int sel, input int n, input string nm);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk(nm, 512'(fin[sel]), 512'd0);
        end
    endtask

    typedef struct {
        int           sel;
        logic [255:0] av;
        logic [255:0] bv;
        logic [511:0] exp;
    } vec_t;

    vec_t tv[7];

    initial begin
        logic [255:0] x, y;
        logic [511:0] keep;
        int acc0;

        tv[0] = '{0, 256'h0000_0001_0000_0002, 256'h0000_0003_0000_0004,
                  512'h0000_0000_0000_0003_0000_000A_0000_0008};
        tv[1] = '{0, 256'hFFFF_FFFF_FFFF_FFFF, 256'hFFFF_FFFF_FFFF_FFFF,
                  512'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        tv[2] = '{1, '1, '1, '0};
        tv[2].exp = tv[2].exp - (512'd1 << 257) + 512'd1;
        tv[3] = '{1, 256'd3, 256'd5, 512'd15};
        tv[4] = '{0, 256'd0, 256'hFFFF_FFFF_FFFF_FFFF, 512'd0};
        tv[5] = '{1, 256'd1 << 255, 256'd2, 512'd1 << 256};
        tv[6] = '{0, 256'hFFFF_FFFF_0000_0000, 256'h1_0000_0000,
                  512'h0000_0000_FFFF_FFFF_0000_0000_0000_0000};

        rst_n = 1'b1; vld = '0; clr = '0; a = '0; b = '0;

        // Reset asserted mid-cycle, released after a few edges.
        #12 rst_n = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy0", 512'(rdy[0]), 512'd1);
        chk("idle_rdy1", 512'(rdy[1]), 512'd1);
        chk("idle_r0", {384'b0, r0}, 512'd0);
        chk("idle_r1", r1, 512'd0);
        no_fin(0, 20, "idle_fin");
        chk("idle_fin1", 512'(fin[1]), 512'd0);

        // Directed vectors.
        for (int i = 0; i < 7; i++)
            do_op(tv[i].sel, tv[i].av, tv[i].bv, tv[i].exp, $sformatf("vec%0d", i));

        // Flush at E+1 with valid held, instance 1.
        keep = r1;
        @(posedge clk); #1;
        a[1] = rnd256(); b[1] = rnd256(); vld[1] = 1'b1;
        @(posedge clk); #1;
        clr[1] = 1'b1;
        @(posedge clk); #1;
        clr[1] = 1'b0; vld[1] = 1'b0;
        @(negedge clk);
        chk("flush_rdy", 512'(rdy[1]), 512'd1);
        no_fin(1, 6, "flush_fin");
        chk("flush_r", r1, keep);

        // Clear together with valid in IDLE is not an accept.
        @(posedge clk); #1;
        clr[1] = 1'b1; vld[1] = 1'b1;
        @(posedge clk); #1;
        clr[1] = 1'b0; vld[1] = 1'b0;
        @(negedge clk);
        chk("clrvld_rdy", 512'(rdy[1]), 512'd1);
        no_fin(1, 6, "clrvld_fin");

        // Flush on the final row edge, instance 0.
        keep = {384'b0, r0};
        @(posedge clk); #1;
        a[0] = rnd256(); b[0] = rnd256(); vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        no_fin(0, 5, "flush_last_fin");
        chk("flush_last_r", {384'b0, r0}, keep);

        x = rnd256(); y = rnd256();
        do_op(1, x, y, ref_mul(1, x, y), "after_flush");

        // Reset in the middle of CALC.
        @(posedge clk); #1;
        a[1] = rnd256(); b[1] = rnd256(); vld[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_r", r1, 512'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        no_fin(1, 6, "rstmid_fin");
        do_op(1, 256'd3, 256'd5, 512'd15, "after_rst");

        // Back-to-back: valid held, new operands every cycle.
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            acc0 = n_acc[s];
            vld[s] = 1'b1;
            for (int k = 0; k < 500 * (lsel(s) + 1); k++) begin
                a[s] = rnd256(); b[s] = rnd256();
                @(posedge clk); #1;
            end
            vld[s] = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            chk($sformatf("throughput%0d", s), 512'(n_acc[s] - acc0), 512'd500);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
